// File: rtl/reg_file_sb_if.sv
// Bus between decode/issue and the register file: ALU write port, load
// write-back port, scoreboard control and the two operand read ports.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              wr_en;
  logic [ADDR_W-1:0] destination;
  logic [DATA_W-1:0] wr_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_dest;
  logic              ld_done;
  logic [ADDR_W-1:0] ld_ret_dest;
  logic [DATA_W-1:0] LDR_mux;
  logic [ADDR_W-1:0] source_1_sel;
  logic [ADDR_W-1:0] source_2_sel;
  logic [DATA_W-1:0] source_1;
  logic [DATA_W-1:0] source_2;
  logic              source_1_busy;
  logic              source_2_busy;
  logic [NREGS-1:0]  busy_vec;
  logic              wr_collide;

  modport master (
    output wr_en, destination, wr_data,
    output ld_issue, ld_dest, ld_done, ld_ret_dest, LDR_mux,
    output source_1_sel, source_2_sel,
    input  source_1, source_2, source_1_busy, source_2_busy,
    input  busy_vec, wr_collide
  );

  modport slave (
    input  wr_en, destination, wr_data,
    input  ld_issue, ld_dest, ld_done, ld_ret_dest, LDR_mux,
    input  source_1_sel, source_2_sel,
    output source_1, source_2, source_1_busy, source_2_busy,
    output busy_vec, wr_collide
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with a per-register load scoreboard.
// Port A (ALU) wins over port L (load return) when both target one register.
module reg_file_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_sb_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_wr_collide;

  logic [NREGS-1:0]  w_wr_hit;
  logic [NREGS-1:0]  w_ld_hit;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_collide;
  logic [DATA_W-1:0] w_source_1;
  logic [DATA_W-1:0] w_source_2;
  logic              w_source_1_busy;
  logic              w_source_2_busy;

  // Per-register decode; masking register 0 here drops its writes, its busy
  // bit and its collisions in one place.
  always_comb begin
    w_wr_hit = '0;
    w_ld_hit = '0;
    w_set    = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_wr_hit[i] = bus.wr_en    && (bus.destination == ADDR_W'(i));
      w_ld_hit[i] = bus.ld_done  && (bus.ld_ret_dest == ADDR_W'(i));
      w_set[i]    = bus.ld_issue && (bus.ld_dest     == ADDR_W'(i));
    end
    if (ZERO_R0 != 0) begin
      w_wr_hit[0] = 1'b0;
      w_ld_hit[0] = 1'b0;
      w_set[0]    = 1'b0;
    end
    w_busy_nxt = (r_busy & ~w_ld_hit) | w_set;
    w_collide  = |(w_wr_hit & w_ld_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy       <= '0;
      r_wr_collide <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_hit[i]) begin
          r_regs[i] <= bus.wr_data;
        end else if (w_ld_hit[i]) begin
          r_regs[i] <= bus.LDR_mux;
        end
      end
      r_busy       <= w_busy_nxt;
      r_wr_collide <= w_collide;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = r_regs[sel];
    if (BYPASS != 0) begin
      if (w_wr_hit[sel]) begin
        v = bus.wr_data;
      end else if (w_ld_hit[sel]) begin
        v = bus.LDR_mux;
      end
    end
    if ((ZERO_R0 != 0) && (sel == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  // A returning load releases its register in the same cycle unless a new
  // load to that register is issued alongside it.
  function automatic logic f_busy(input logic [ADDR_W-1:0] sel);
    logic b;
    b = r_busy[sel];
    if ((BYPASS != 0) && w_ld_hit[sel] && !w_set[sel]) begin
      b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    w_source_1      = f_read(bus.source_1_sel);
    w_source_2      = f_read(bus.source_2_sel);
    w_source_1_busy = f_busy(bus.source_1_sel);
    w_source_2_busy = f_busy(bus.source_2_sel);
  end

  assign bus.source_1      = w_source_1;
  assign bus.source_2      = w_source_2;
  assign bus.source_1_busy = w_source_1_busy;
  assign bus.source_2_busy = w_source_2_busy;
  assign bus.busy_vec      = r_busy;
  assign bus.wr_collide    = r_wr_collide;
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Clocked, parametrised register file with two read ports and two write ports.
- Successor to the level-sensitive 16x32 register bank with its one-hot decoder and two 16:1 source muxes.
- Write port A takes the ALU result. Write port L takes returning load data from the LDR path.
- A per-register scoreboard marks registers with an outstanding load, so the issue logic can stall on source_1/source_2 hazards. Sits between instruction decode and the ALU operand inputs.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, select width; number of registers NREGS = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports (write-first); 0 = reads return pre-write value.
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes and is never marked busy.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- wr_en  in  1  ALU write strobe.
- destination  in  ADDR_W  ALU write address.
- wr_data  in  DATA_W  ALU write data.
- ld_issue  in  1  load issued; marks ld_dest busy.
- ld_dest  in  ADDR_W  target register of the issued load.
- ld_done  in  1  load data returning on LDR_mux.
- ld_ret_dest  in  ADDR_W  target register of returning load.
- LDR_mux  in  DATA_W  returning load data.
- source_1_sel  in  ADDR_W  read port 1 address.
- source_2_sel  in  ADDR_W  read port 2 address.
- source_1  out  DATA_W  read port 1 data (combinational from sel).
- source_2  out  DATA_W  read port 2 data.
- source_1_busy  out  1  selected register has an outstanding load.
- source_2_busy  out  1  selected register has an outstanding load.
- busy_vec  out  NREGS  scoreboard bits, bit i = register i.
- wr_collide  out  1  registered pulse: wr_en and ld_done hit the same register last cycle.

Behaviour:
- Reset (reset=1 at edge): all registers cleared to 0, busy_vec cleared to 0, wr_collide cleared to 0. Any write or issue in that cycle is ignored. After reset, source_1 = source_2 = 0 and both busy outputs = 0.
- Writes take effect at the rising edge. Both ports may write different registers in the same cycle.
- Same register written by both ports in one cycle:
  - Port A (wr_en) data is stored (ALU result is the younger value).
  - The busy bit is cleared.
  - wr_collide = 1 for exactly the next cycle.
- Scoreboard, per register i, evaluated at each edge:
  - set when ld_issue and ld_dest == i;
  - clear when ld_done and ld_ret_dest == i;
  - set and clear in the same cycle: set wins (busy stays 1, new load outstanding);
  - wr_en to a busy register writes data but does not clear busy;
  - ld_done to a non-busy register still writes data; busy stays 0.
- Reads are combinational: source_n = reg[source_n_sel].
- BYPASS=1, forwarding in the write cycle:
  - source_n_sel == destination with wr_en: read wr_data.
  - source_n_sel == ld_ret_dest with ld_done: read LDR_mux.
  - Both match: read wr_data.
- BYPASS=1, busy output in the write cycle: source_n_busy is 0 when ld_done targets source_n_sel, unless ld_issue targets the same register in that cycle.
- BYPASS=0: read ports and busy outputs reflect only stored state.
- ZERO_R0=1: reads of register 0 return 0, writes to register 0 are dropped, busy_vec[0] is forced to 0, and collisions on register 0 do not pulse wr_collide.
- No undefined or high-impedance read output for any select value.
- Latency: write-to-read is 1 cycle through storage, or 0 with BYPASS. Scoreboard set is visible the cycle after ld_issue.

Test Plan:
- Reset, then read all 16 selects on both ports -> every value 0x00000000, busy_vec = 0x0000, wr_collide = 0.
- wr_en, destination=3, wr_data=0xDEADBEEF. Same cycle source_1_sel=3 -> source_1 = 0xDEADBEEF with BYPASS=1, or 0x00000000 with BYPASS=0. Next cycle -> 0xDEADBEEF either way.
- ld_issue, ld_dest=5 -> next cycle busy_vec[5]=1 and source_2_busy=1 with source_2_sel=5. Two cycles later ld_done, ld_ret_dest=5, LDR_mux=0x12345678 -> following cycle busy_vec[5]=0, source_2 = 0x12345678.
- Same cycle: ld_done ld_ret_dest=7, and ld_issue ld_dest=7 -> busy_vec[7] remains 1, register 7 holds the LDR_mux value.
- Same cycle: wr_en destination=9 wr_data=0xAAAA0000, and ld_done ld_ret_dest=9 LDR_mux=0x5555FFFF -> reg 9 = 0xAAAA0000, busy_vec[9]=0, wr_collide=1 for one cycle only.
- ZERO_R0=1: wr_en destination=0 wr_data=0xFFFFFFFF, and ld_issue ld_dest=0 -> source_1 (sel 0) = 0, busy_vec[0]=0. Assert reset mid-load on reg 2 -> busy_vec cleared and the later ld_done writes data without setting busy.
